// File: rtl/circle_buf_pkg.sv
// Shared types and status-word field positions for the circle_buf readout path.
package circle_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // buf_stat layout: write address in the low aw bits, record type in bit 15
    localparam int STAT_ADDR_LSB     = 0;
    localparam int STAT_REC_TYPE_BIT = 15;

endpackage

// File: rtl/circle_buf_skid.sv
// Two-entry output FIFO; head entry drives the outputs directly from flops.
module circle_buf_skid #(
    parameter int w = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [w-1:0] push_data,
    input  logic         pop,
    output logic [w-1:0] head,
    output logic         valid,
    output logic [1:0]   count
);

    logic [w-1:0] tail;

    assign valid = (count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= push_data;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= push_data;
                    end else if (push) begin
                        tail  <= push_data;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    // a push while full is never issued by the reader
                    if (pop) begin
                        head <= tail;
                        if (push) tail <= push_data;
                        else      count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/circle_buf_reader.sv
// Paced frame readout of a circle_buf into a 2-deep output FIFO.
// Optional header word before each frame: define CIRCLE_BUF_READER_HDR_EN.
module circle_buf_reader
    import circle_buf_pkg::*;
#(
    parameter int aw   = 6,
    parameter int dw   = 16,
    parameter int pace = 4
) (
    input  logic          oclk,
    input  logic          rst,
    input  logic          run,
    input  logic          enable,
    input  logic [15:0]   buf_stat,
    input  logic [dw-1:0] d_in,
    output logic [aw-1:0] read_addr,
    output logic          stb_out,
    output logic [dw-1:0] o_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic          o_last,
    output logic          busy,
    output logic [15:0]   frame_cnt
);

    localparam logic [aw-1:0] ADDR_MAX    = '1;
    localparam logic [3:0]    PACE_RELOAD = 4'(pace - 1);

    state_t        state;
    logic [3:0]    pace_cnt;
    logic          in_flight;
    logic          in_flight_last;
    logic [1:0]    fifo_count;
    logic [2:0]    occupancy;
    logic          strobe_ok;
    logic          push;
    logic          pop;
    logic [dw:0]   push_word;
    logic [dw:0]   head_word;

`ifdef CIRCLE_BUF_READER_HDR_EN
    assign push      = in_flight | (state == HDR);
    assign push_word = in_flight ? {in_flight_last, d_in} : {1'b0, dw'(buf_stat)};
`else
    logic unused_stat;
    assign unused_stat = ^buf_stat;
    assign push        = in_flight;
    assign push_word   = {in_flight_last, d_in};
`endif

    assign pop       = o_valid & o_ready;
    assign o_data    = head_word[dw-1:0];
    assign o_last    = head_word[dw];
    assign busy      = (state != IDLE);
    // buffered words plus strobes whose data has not landed yet
    assign occupancy = {1'b0, fifo_count} + {2'b0, in_flight} + {2'b0, stb_out};
    assign strobe_ok = (state == READ) && !stb_out && (pace_cnt == 4'd0) && (occupancy < 3'd2);

    circle_buf_skid #(.w(dw + 1)) u_skid (
        .clk       (oclk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head_word),
        .valid     (o_valid),
        .count     (fifo_count)
    );

    always_ff @(posedge oclk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            read_addr      <= '0;
            stb_out        <= 1'b0;
            pace_cnt       <= 4'd0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            frame_cnt      <= 16'd0;
        end else begin
            in_flight      <= stb_out;
            in_flight_last <= stb_out && (read_addr == ADDR_MAX);
            stb_out        <= 1'b0;
            if (pace_cnt != 4'd0) pace_cnt <= pace_cnt - 4'd1;
            if (stb_out) read_addr <= read_addr + 1'b1;
            case (state)
                IDLE: begin
                    if (run && enable) begin
`ifdef CIRCLE_BUF_READER_HDR_EN
                        state <= HDR;
`else
                        state <= READ;
`endif
                    end
                end
`ifdef CIRCLE_BUF_READER_HDR_EN
                HDR: state <= READ;
`endif
                READ: begin
                    if (strobe_ok) begin
                        stb_out  <= 1'b1;
                        pace_cnt <= PACE_RELOAD;
                    end
                    if (stb_out && (read_addr == ADDR_MAX)) state <= DRAIN;
                end
                DRAIN: begin
                    if ((fifo_count == 2'd0) && !in_flight) begin
                        state     <= IDLE;
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_circle_buf_reader.sv
// Directed bench for circle_buf_reader; header-word cases follow CIRCLE_BUF_READER_HDR_EN.
module tb_circle_buf_reader;

    localparam int AW     = 6;
    localparam int DW     = 16;
    localparam int PACE   = 4;
    localparam int NWORDS = 64;
`ifdef CIRCLE_BUF_READER_HDR_EN
    localparam int HW = 1;
`else
    localparam int HW = 0;
`endif

    logic          oclk = 1'b0;
    logic          rst, run, enable, o_ready;
    logic [15:0]   buf_stat;
    logic [DW-1:0] d_in;
    logic [AW-1:0] read_addr;
    logic          stb_out, o_valid, o_last, busy;
    logic [DW-1:0] o_data;
    logic [15:0]   frame_cnt;

    int errors = 0;
    int checks = 0;
    int frames_total = 0;
    int exp_idx, n_strobes, last_stb, first_stb, cyc;

    circle_buf_reader #(.aw(AW), .dw(DW), .pace(PACE)) dut (
        .oclk      (oclk),
        .rst       (rst),
        .run       (run),
        .enable    (enable),
        .buf_stat  (buf_stat),
        .d_in      (d_in),
        .read_addr (read_addr),
        .stb_out   (stb_out),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_last    (o_last),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 oclk = ~oclk;

    // circle_buf model: data for a strobed address appears on the following cycle
    always @(posedge oclk) if (stb_out) d_in <= 16'hC000 | 16'(read_addr);

    function automatic logic [15:0] exp_word(input int k);
        return (k < HW) ? buf_stat : (16'hC000 | 16'(k - HW));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"},  32'(read_addr), 0);
        check({tag, "_stb"},   32'(stb_out),   0);
        check({tag, "_valid"}, 32'(o_valid),   0);
        check({tag, "_last"},  32'(o_last),    0);
        check({tag, "_data"},  32'(o_data),    0);
        check({tag, "_busy"},  32'(busy),      0);
        check({tag, "_fcnt"},  32'(frame_cnt), 0);
    endtask

    task automatic frame(input int frames, input int stall_at, input int drop_at,
                         input int reset_at, input bit exact);
        int done = 0;
        int stall_left = 0;
        bit stalled = 0;
        bit prev_busy = 0;
        logic [DW-1:0] held = '0;
        exp_idx = 0; n_strobes = 0; last_stb = -1000; first_stb = -1000; cyc = 0;
        while (done < frames && cyc < 3000 * frames) begin
            @(negedge oclk);
            cyc++;
            if (reset_at >= 0 && stb_out && read_addr == AW'(reset_at)) begin
                #2 rst = 1'b1;
                #1 check_reset("midrst");
                run = 1'b0; enable = 1'b0;
                @(negedge oclk);
                rst = 1'b0;
                frames_total = 0;
                return;
            end
            if (stall_at >= 0 && !stalled && n_strobes == stall_at) begin
                stalled = 1'b1; o_ready = 1'b0; stall_left = 50;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 35) held = o_data;
                if (stall_left < 35 && stall_left > 0) begin
                    check("stall_no_stb", 32'(stb_out), 0);
                    check("stall_valid",  32'(o_valid), 1);
                    check("stall_hold",   32'(o_data),  32'(held));
                end
                if (stall_left == 0) begin
                    check("stall_buffered", n_strobes + HW - exp_idx, 2);
                    o_ready = 1'b1;
                end
            end
            if (drop_at >= 0 && stb_out && read_addr == AW'(drop_at)) begin
                enable = 1'b0; run = 1'b0;
            end
            if (stb_out) begin
                check("addr", 32'(read_addr), n_strobes);
                if (n_strobes > 0) begin
                    if (exact) check("spacing", cyc - last_stb, PACE);
                    else       check("spacing_min", 32'((cyc - last_stb) >= PACE), 1);
                end else begin
                    first_stb = cyc;
                end
                last_stb = cyc;
                n_strobes++;
            end
            if (o_valid && o_ready) begin
                if (exact && HW == 0 && exp_idx == 0) check("latency", cyc - first_stb, 2);
                check("data", 32'(o_data), 32'(exp_word(exp_idx)));
                check("last", 32'(o_last), 32'(exp_idx == NWORDS + HW - 1));
                exp_idx++;
            end
            if (prev_busy && !busy) begin
                check("words", exp_idx, NWORDS + HW);
                check("strobes", n_strobes, NWORDS);
                frames_total++;
                check("frame_cnt", 32'(frame_cnt), frames_total);
                done++;
                exp_idx = 0; n_strobes = 0; last_stb = -1000; first_stb = -1000;
                if (done == frames) begin
                    run = 1'b0; enable = 1'b0;
                end
            end
            prev_busy = busy;
        end
        if (done < frames) check("timeout", done, frames);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; enable = 1'b0; o_ready = 1'b1; buf_stat = 16'h8025;
        repeat (2) @(negedge oclk);
        check_reset("init");
        rst = 1'b0;
        @(negedge oclk);
        check("idle_busy", 32'(busy), 0);

        // single free-running frame
        run = 1'b1; enable = 1'b1;
        frame(1, -1, -1, -1, 1'b1);

        // either arm signal alone must not start a frame
        run = 1'b0; enable = 1'b1;
        repeat (4) @(negedge oclk);
        check("enable_only_busy", 32'(busy), 0);
        run = 1'b1; enable = 1'b0;
        repeat (4) @(negedge oclk);
        check("run_only_busy", 32'(busy), 0);
        check("run_only_stb", 32'(stb_out), 0);

        // downstream stall mid-frame
        run = 1'b1; enable = 1'b1;
        frame(1, 10, -1, -1, 1'b0);

        // arm signals dropped mid-frame
        run = 1'b1; enable = 1'b1;
        frame(1, -1, 20, -1, 1'b1);

        // reset mid-frame
        run = 1'b1; enable = 1'b1;
        frame(1, -1, -1, 30, 1'b1);
        repeat (3) @(negedge oclk);
        check("post_rst_fcnt", 32'(frame_cnt), 0);
        check("post_rst_addr", 32'(read_addr), 0);

        // back-to-back frames with run held high
        run = 1'b1; enable = 1'b1;
        frame(3, -1, -1, -1, 1'b1);
        check("three_frames", 32'(frame_cnt), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/circle_buf_reader.md
CIRCLE_BUF_READER -- requirements
Module: circle_buf_reader

Interface
REQ-001 Parameter aw, default 6, SHALL set the buffer address width; a frame SHALL be 2**aw words.
REQ-002 Parameter dw, default 16, SHALL set the data width.
REQ-003 Parameter pace, default 4, legal range 2..15, SHALL set the minimum oclk cycles between consecutive read strobes.
REQ-004 oclk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 run  in  1  arm readout; level-sensitive.
REQ-007 enable  in  1  buffer-ready flag from circle_buf.
REQ-008 buf_stat  in  16  circle_buf status word.
REQ-009 d_in  in  dw  circle_buf read data, valid one cycle after stb_out.
REQ-010 read_addr  out  aw  circle_buf read address.
REQ-011 stb_out  out  1  circle_buf read strobe.
REQ-012 o_data  out  dw  output word.
REQ-013 o_valid  out  1  output word valid.
REQ-014 o_ready  in  1  downstream accept; a transfer occurs when o_valid & o_ready.
REQ-015 o_last  out  1  marks the final word of a frame; qualified by o_valid.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.
REQ-017 frame_cnt  out  16  count of completed frames; wraps at 65535->0.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, HDR, READ and DRAIN.
REQ-019 IDLE->HDR (or READ when the macro is off) SHALL occur when run & enable are both high on a clock edge.
REQ-020 enable and run SHALL be ignored outside IDLE; their deassertion mid-frame SHALL NOT abort the frame.
REQ-021 In READ, the block SHALL issue one stb_out per address, 0 through 2**aw-1 in ascending order, holding read_addr stable during stb_out.
REQ-022 A strobe SHALL be issued only when the pace counter has expired and (FIFO occupancy + reads in flight) < 2.
REQ-023 Each strobe SHALL reload the pace counter to pace-1.
REQ-024 Latency: stb_out at cycle t SHALL write d_in into the FIFO at edge t+1, and o_valid SHALL be high at t+2 when the FIFO was empty.
REQ-025 read_addr SHALL increment after each strobe and wrap to 0 after 2**aw-1; READ->DRAIN SHALL follow the last strobe.
REQ-026 DRAIN->IDLE SHALL occur when the FIFO is empty with nothing in flight; frame_cnt SHALL increment on that same edge.
REQ-027 o_last SHALL accompany the word read from address 2**aw-1 only.
REQ-028 A FIFO push and a pop in the same cycle SHALL both be honoured; the FIFO SHALL never overflow and SHALL never present stale data.
REQ-029 With o_ready held low, reads SHALL stall after 2 words are buffered, and o_data SHALL remain stable while o_valid is high.

Reset
REQ-030 While rst is asserted the block SHALL enter IDLE asynchronously, with read_addr=0, stb_out=0, o_valid=0, o_last=0, o_data=0, busy=0, frame_cnt=0, FIFO empty and pace counter=0.
REQ-031 Reset mid-frame SHALL discard in-flight data; the next frame SHALL restart at address 0.

Configuration
REQ-032 With CIRCLE_BUF_READER_HDR_EN defined, HDR SHALL push one header word, {buf_stat} zero-extended or truncated to dw, into the FIFO before address 0, and then go to READ.
REQ-033 Without CIRCLE_BUF_READER_HDR_EN, the HDR state and its logic SHALL be absent, and a frame SHALL be exactly 2**aw words.

Structure
REQ-034 Package circle_buf_pkg SHALL hold the FSM state typedef and the buf_stat field constants (addr field [aw-1:0], record_type bit 15).
REQ-035 The 2-entry output FIFO SHALL be a sub-module named circle_buf_skid.

Verification
REQ-036 aw=6, pace=4, o_ready=1, enable and run high -> 64 strobes spaced 4 cycles apart, read_addr 0..63, o_last on word 64, frame_cnt=1.
REQ-037 o_ready=0 for 50 cycles mid-frame -> exactly 2 words buffered, no strobes, o_data stable; on release the data resumes with no loss or duplication.
REQ-038 enable dropped at read_addr=20 -> the frame completes all 64 words and busy falls only after DRAIN.
REQ-039 rst pulsed at read_addr=30 -> outputs at reset values immediately; the next frame starts at address 0.
REQ-040 HDR_EN defined, buf_stat=16'h8025 -> first word 16'h8025, then 64 data words, o_last on word 65.
REQ-041 run held high for 3 frames -> frame_cnt=3 and each frame is preceded by an IDLE cycle.
